// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: in-order write queue drained into the register file,
// plus a one-deep operand-read response stage that forwards from queued writes.
module regfile_access_ctrl #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wq_valid,
  output logic             wq_ready,
  input  logic [4:0]       wq_addr,
  input  logic [WIDTH-1:0] wq_data,
  input  logic             drain_en,
  input  logic             rd_valid,
  output logic             rd_ready,
  input  logic [4:0]       rd_ra,
  input  logic [4:0]       rd_rb,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_a,
  output logic [WIDTH-1:0] rsp_b,
  output logic             rf_en,
  output logic [4:0]       rf_rw,
  output logic [WIDTH-1:0] rf_data,
  output logic [4:0]       rf_ra,
  output logic [4:0]       rf_rb,
  input  logic [WIDTH-1:0] rf_dra,
  input  logic [WIDTH-1:0] rf_drb
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [4:0] ZERO_REG = 5'd31;

  typedef enum logic {S_EMPTY, S_HOLD} rd_state_e;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [4:0]       addr_mem [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];

  rd_state_e        state_q, state_d;
  logic [WIDTH-1:0] rsp_a_q, rsp_a_d;
  logic [WIDTH-1:0] rsp_b_q, rsp_b_d;
  logic [WIDTH-1:0] fwd_a, fwd_b;
  logic [PW-1:0]    slot;

  logic push, pop, rd_accept;

  // Writes to the hard-zero register are acknowledged but never stored.
  assign wq_ready  = (count_q < CW'(DEPTH));
  assign push      = wq_valid && wq_ready && (wq_addr != ZERO_REG);
  assign rf_en     = (count_q != '0) && drain_en;
  assign pop       = rf_en;
  assign rf_rw     = addr_mem[rd_ptr_q];
  assign rf_data   = data_mem[rd_ptr_q];
  assign rf_ra     = rd_ra;
  assign rf_rb     = rd_rb;
  assign rsp_valid = (state_q == S_HOLD);
  assign rd_ready  = !rsp_valid || rsp_ready;
  assign rd_accept = rd_valid && rd_ready;
  assign rsp_a     = rsp_a_q;
  assign rsp_b     = rsp_b_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= wq_addr;
      data_mem[wr_ptr_q] <= wq_data;
    end
  end

  // Scan oldest to youngest so the last match wins; the popping head is still visible.
  always_comb begin
    fwd_a = rf_dra;
    fwd_b = rf_drb;
    slot  = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (addr_mem[slot] == rd_ra) fwd_a = data_mem[slot];
        if (addr_mem[slot] == rd_rb) fwd_b = data_mem[slot];
      end
    end
    if (rd_ra == ZERO_REG) fwd_a = '0;
    if (rd_rb == ZERO_REG) fwd_b = '0;
  end

  always_comb begin
    state_d = state_q;
    rsp_a_d = rsp_a_q;
    rsp_b_d = rsp_b_q;
    case (state_q)
      S_EMPTY: begin
        if (rd_accept) begin
          state_d = S_HOLD;
          rsp_a_d = fwd_a;
          rsp_b_d = fwd_b;
        end
      end
      S_HOLD: begin
        if (rd_accept) begin
          state_d = S_HOLD;
          rsp_a_d = fwd_a;
          rsp_b_d = fwd_b;
        end else if (rsp_ready) begin
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      rsp_a_q <= '0;
      rsp_b_q <= '0;
    end else begin
      state_q <= state_d;
      rsp_a_q <= rsp_a_d;
      rsp_b_q <= rsp_b_d;
    end
  end

endmodule

// File: doc/regfile_access_ctrl.md
REGFILE_ACCESS_CTRL -- requirements
Module: regfile_access_ctrl

Interface
REQ-001 Parameter: DEPTH, 4, write-queue entries (power of two, >=2).
REQ-002 Parameter: WIDTH, 64, data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 wq_valid  input  1  write request valid.
REQ-006 wq_ready  output  1  write request accepted this cycle when high with wq_valid.
REQ-007 wq_addr  input  5  destination register index.
REQ-008 wq_data  input  WIDTH  write data.
REQ-009 drain_en  input  1  permits issuing one queued write to the register file this cycle.
REQ-010 rd_valid  input  1  operand-read request valid.
REQ-011 rd_ready  output  1  read request accepted when high with rd_valid.
REQ-012 rd_ra, rd_rb  input  5 each  operand A/B register indices.
REQ-013 rsp_valid  output  1  read response valid.
REQ-014 rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-015 rsp_a, rsp_b  output  WIDTH each  operand A/B response data.
REQ-016 rf_en, rf_rw, rf_data  output  1/5/WIDTH  register-file write enable, index, data.
REQ-017 rf_ra, rf_rb  output  5 each  register-file read indices.
REQ-018 rf_dra, rf_drb  input  WIDTH each  register-file combinational read data.

Function
REQ-019 Write queue SHALL be an in-order FIFO of DEPTH {addr,data} entries with occupancy counter 0..DEPTH.
REQ-020 wq_ready SHALL equal (count < DEPTH); no same-cycle pass-through when full.
REQ-021 Accepted write with wq_addr==31 SHALL be dropped (not enqueued); index 31 is hard zero.
REQ-022 rf_en SHALL equal (count!=0 && drain_en); rf_rw/rf_data SHALL present the head entry; head pops at the edge where rf_en is high.
REQ-023 Simultaneous enqueue and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-024 rf_ra/rf_rb SHALL combinationally equal rd_ra/rd_rb.
REQ-025 rd_ready SHALL equal (!rsp_valid || rsp_ready).
REQ-026 On read acceptance, rsp_a/rsp_b SHALL register next edge; rsp_valid high one cycle after acceptance (latency 1).
REQ-027 Operand value SHALL be: 0 if index==31; else data of youngest queue entry with matching addr (including head popping that cycle); else rf_dra/rf_drb.
REQ-028 A write accepted in the same cycle as a read SHALL NOT be forwarded to that read.
REQ-029 rsp_valid/rsp_a/rsp_b SHALL hold stable while rsp_valid && !rsp_ready.
REQ-030 rsp_valid SHALL clear after rsp_ready handshake unless a new read is accepted that same cycle (back-to-back, one response per cycle).
REQ-031 Read path states: EMPTY (rsp_valid=0) and HOLD (rsp_valid=1); EMPTY->HOLD on accept; HOLD->EMPTY on rsp_ready without new accept; HOLD->HOLD otherwise.

Reset
REQ-032 rst_n low SHALL immediately: count=0, pointers=0, rsp_valid=0, rsp_a=rsp_b=0, rf_en=0.
REQ-033 Reset mid-operation SHALL discard queued writes and pending response; no rf_en pulse after release until a new write is queued.
REQ-034 After rst_n rises, wq_ready=1 and rd_ready=1 on the first cycle.

Verification
REQ-035 drain_en=0, write r3=0xA1,r3=0xB2,r5=0xC3,r7=0xD4 -> count=4, wq_ready=0; fifth write stalls.
REQ-036 Queue {r3=0xA1,r3=0xB2}, rf_dra=0, read ra=3 -> rsp_a=0xB2 next cycle.
REQ-037 Read ra=31,rb=31 with queued write to 31 attempted -> write dropped, rsp_a=rsp_b=0.
REQ-038 rsp_ready=0 two cycles after response -> rsp_a/rsp_b/rsp_valid unchanged, rd_ready=0; then rsp_ready=1 with rd_valid=1 -> new response next cycle.
REQ-039 drain_en=1 from full -> rf_en high 4 consecutive cycles, rf_rw order 3,3,5,7, then count=0.
REQ-040 Assert rst_n=0 mid-drain with count=2 -> rf_en and rsp_valid low asynchronously, count=0 after release.
